// File: rtl/sample_delay_line.sv
// Circular block-RAM sample buffer returning x[n-d] for the modulated-delay tap.
// Each accepted strobe walks IDLE -> WRITE -> READ -> OUT and emits one valid pulse.
module sample_delay_line #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clkI2s,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  sample_i,
   input  logic              sampleStrobe_i,
   input  logic [ADDR_W-1:0] delay_i,
   input  logic              clear_i,
   output logic [WIDTH-1:0]  delayed_o,
   output logic              delayedValid_o,
   output logic              primed_o,
   output logic              overrun_o
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_OUT} state_t;

   localparam logic [ADDR_W:0] C_FULL = (ADDR_W+1)'(DEPTH);

   state_t            r_state;
   state_t            w_state_next;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [WIDTH-1:0]  r_sample;
   logic [WIDTH-1:0]  r_rdata;
   logic [ADDR_W-1:0] r_delay;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_raddr;
   logic [ADDR_W:0]   r_fill_cnt;
   logic [ADDR_W:0]   w_fill_inc;
   logic              w_accept;
   logic              w_write_en;
   logic              w_read_en;
   logic              w_out_en;
   logic              w_drop;

   always_ff @(posedge clkI2s or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (clear_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (sampleStrobe_i) w_state_next = S_WRITE;
         S_WRITE: w_state_next = S_READ;
         S_READ:  w_state_next = S_OUT;
         S_OUT:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // clear_i suppresses every side effect of the current cycle, including overrun.
   always_comb begin
      w_accept   = (r_state == S_IDLE)  && sampleStrobe_i && !clear_i;
      w_write_en = (r_state == S_WRITE) && !clear_i;
      w_read_en  = (r_state == S_READ);
      w_out_en   = (r_state == S_OUT)   && !clear_i;
      w_drop     = (r_state != S_IDLE)  && sampleStrobe_i && !clear_i;
      w_fill_inc = (r_fill_cnt == C_FULL) ? r_fill_cnt : r_fill_cnt + 1'b1;
   end

   always_ff @(posedge clkI2s or negedge rst_n) begin
      if (!rst_n) begin
         r_sample       <= '0;
         r_delay        <= '0;
         r_wr_ptr       <= '0;
         r_raddr        <= '0;
         r_fill_cnt     <= '0;
         delayed_o      <= '0;
         delayedValid_o <= 1'b0;
         primed_o       <= 1'b0;
         overrun_o      <= 1'b0;
      end else if (clear_i) begin
         r_wr_ptr       <= '0;
         r_fill_cnt     <= '0;
         delayedValid_o <= 1'b0;
         primed_o       <= 1'b0;
         overrun_o      <= 1'b0;
      end else begin
         delayedValid_o <= w_out_en;
         if (w_accept) begin
            r_sample <= sample_i;
            r_delay  <= delay_i;
         end
         if (w_write_en) begin
            // Pre-increment pointer, so d=0 addresses the slot being written now.
            r_raddr    <= r_wr_ptr - r_delay;
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_fill_cnt <= w_fill_inc;
            primed_o   <= (w_fill_inc == C_FULL);
         end
         if (w_out_en) begin
            delayed_o <= ({1'b0, r_delay} < r_fill_cnt) ? r_rdata : '0;
         end
         if (w_drop) begin
            overrun_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clkI2s) begin
      if (w_write_en) begin
         r_mem[r_wr_ptr] <= r_sample;
      end
      if (w_read_en) begin
         r_rdata <= r_mem[r_raddr];
      end
   end

endmodule

// File: tb/tb_sample_delay_line.sv
// Scoreboard bench for sample_delay_line (DEPTH=8 build to exercise wrap and priming).
// Expected taps come from a history queue of written samples since reset/clear.
module tb_sample_delay_line;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst_n;
   logic [WIDTH-1:0]  sample_i;
   logic              sampleStrobe_i;
   logic [AW-1:0]     delay_i;
   logic              clear_i;
   logic [WIDTH-1:0]  delayed_o;
   logic              delayedValid_o;
   logic              primed_o;
   logic              overrun_o;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic exp_ovr = 1'b0;
   logic [WIDTH-1:0] hist[$];
   logic [WIDTH-1:0] exp_q[$];
   int               cyc_q[$];

   sample_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clkI2s         (clk),
      .rst_n          (rst_n),
      .sample_i       (sample_i),
      .sampleStrobe_i (sampleStrobe_i),
      .delay_i        (delay_i),
      .clear_i        (clear_i),
      .delayed_o      (delayed_o),
      .delayedValid_o (delayedValid_o),
      .primed_o       (primed_o),
      .overrun_o      (overrun_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_flush();
      hist.delete();
      exp_q.delete();
      cyc_q.delete();
      exp_ovr = 1'b0;
   endtask

   // Issue an accepted strobe at a negedge; expected tap is x[n-d] or 0 if not yet written.
   task automatic send(input logic [WIDTH-1:0] s, input int d, input int gap);
      logic [WIDTH-1:0] e;
      sample_i       = s;
      delay_i        = d[AW-1:0];
      sampleStrobe_i = 1'b1;
      hist.push_back(s);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      e = (d < hist.size()) ? hist[hist.size()-1-d] : '0;
      exp_q.push_back(e);
      cyc_q.push_back(cyc + 4);
      @(negedge clk);
      sampleStrobe_i = 1'b0;
      sample_i       = WIDTH'($urandom);
      delay_i        = AW'($urandom);
      repeat (gap-1) @(negedge clk);
      if (gap >= 4) begin
         chk("primed", primed_o, hist.size() == DEPTH);
         chk("overrun", overrun_o, exp_ovr);
      end
   endtask

   task automatic raw_strobe(input logic [WIDTH-1:0] s);
      sample_i       = s;
      sampleStrobe_i = 1'b1;
      @(negedge clk);
      sampleStrobe_i = 1'b0;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      model_flush();
      chk("clear_primed", primed_o, 1'b0);
      chk("clear_overrun", overrun_o, 1'b0);
   endtask

   // Monitor: pops one expectation per valid pulse, checking data and latency.
   always @(negedge clk) begin : monitor
      logic [WIDTH-1:0] e;
      int c;
      if (rst_n && delayedValid_o) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got pulse with delayed_o=%h, required no pulse (cycle %0d)", delayed_o, cyc);
         end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            $display("[TB] out delayed_o=%h expected=%h cycle=%0d", delayed_o, e, cyc);
            chk("data", delayed_o, e);
            chk("latency", cyc, c);
         end
      end
   end

   initial begin
      rst_n = 1'b0; sample_i = '0; sampleStrobe_i = 1'b0; delay_i = '0; clear_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_delayed", delayed_o, '0);
      chk("rst_valid", delayedValid_o, 1'b0);
      chk("rst_primed", primed_o, 1'b0);
      chk("rst_overrun", overrun_o, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // delay 0 returns the sample just written
      for (int i = 1; i <= 5; i++) send(WIDTH'(i), 0, 32);

      // delay 4 with unprimed head
      do_clear();
      for (int i = 0; i < 10; i++) send(WIDTH'(16'h0100 + i), 4, 8);

      // wrap and priming with maximum delay
      do_clear();
      for (int i = 0; i < 20; i++) send(WIDTH'(i), DEPTH-1, 6);

      // random traffic at legal spacing
      for (int i = 0; i < 40; i++)
         send(WIDTH'($urandom), int'($urandom_range(0, DEPTH-1)), int'($urandom_range(4, 12)));

      // too-close strobe is dropped and overrun sticks
      send(16'hAAAA, 0, 2);
      raw_strobe(16'h5555);
      exp_ovr = 1'b1;
      repeat (4) @(negedge clk);
      chk("overrun_set", overrun_o, 1'b1);
      for (int i = 0; i < 3; i++) send(WIDTH'($urandom), int'($urandom_range(0, DEPTH-1)), 6);

      // async reset mid-operation, between edges
      raw_strobe(16'h7E57);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_delayed", delayed_o, '0);
      chk("arst_valid", delayedValid_o, 1'b0);
      chk("arst_primed", primed_o, 1'b0);
      chk("arst_overrun", overrun_o, 1'b0);
      model_flush();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'hBEEF, 1, 6);
      send(16'hCAFE, 0, 6);
      send(16'h1111, 1, 6);
      send(16'h2222, 3, 6);

      // overrun again, then cleared by clear_i
      send(16'h3333, 0, 2);
      raw_strobe(16'h4444);
      exp_ovr = 1'b1;
      repeat (4) @(negedge clk);
      chk("overrun_set2", overrun_o, 1'b1);
      do_clear();

      // clear while in READ aborts the pulse
      send(16'h0F0F, 0, 6);
      raw_strobe(16'h9999);
      @(negedge clk);
      do_clear();
      repeat (5) @(negedge clk);
      send(16'h1234, 1, 8);
      send(16'h5678, 1, 8);

      repeat (6) @(negedge clk);
      chk("pending_outputs", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
